// File: rtl/snn_fp_pkg.sv
// Shared FP32 field layout, classification helpers and LIF neuron state encoding.
package snn_fp_pkg;

  localparam int unsigned FP_EXP_MSB  = 30;
  localparam int unsigned FP_EXP_LSB  = 23;
  localparam int unsigned FP_MANT_W   = 23;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_POS_ONE  = 32'h3F80_0000;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    INTEG  = 2'd0,
    FIRE   = 2'd1,
    REFRAC = 2'd2
  } lif_state_t;

  // All-ones exponent with a non-zero mantissa.
  function automatic logic is_nan(input logic [31:0] x);
    return (x[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_MAX) && (x[FP_MANT_W-1:0] != '0);
  endfunction

  // All-ones exponent with a zero mantissa (either sign).
  function automatic logic is_inf(input logic [31:0] x);
    return (x[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_MAX) && (x[FP_MANT_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/fp32_ge_cmp.sv
// Combinational FP32 a >= b in sign-magnitude form; denormals and both zeros compare as zero.
module fp32_ge_cmp
  import snn_fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ge
);

  fp32_t       fa;
  fp32_t       fb;
  logic        a_zero;
  logic        b_zero;
  logic        a_neg;
  logic        b_neg;
  logic [30:0] a_mag;
  logic [30:0] b_mag;

  // Flush denormals to zero, then order by effective sign and magnitude.
  always_comb begin
    fa     = fp32_t'(a);
    fb     = fp32_t'(b);
    a_zero = (fa.exp == 8'd0);
    b_zero = (fb.exp == 8'd0);
    a_neg  = fa.sign & ~a_zero;
    b_neg  = fb.sign & ~b_zero;
    a_mag  = a_zero ? 31'd0 : {fa.exp, fa.mant};
    b_mag  = b_zero ? 31'd0 : {fb.exp, fb.mant};
    ge     = 1'b0;
    if (a_neg != b_neg) begin
      ge = ~a_neg;
    end else if (!a_neg) begin
      ge = (a_mag >= b_mag);
    end else begin
      ge = (a_mag <= b_mag);
    end
  end

endmodule

// File: rtl/lif_neuron_fp32.sv
// FP32 leaky-integrate-and-fire membrane stage: stores adder results, fires on threshold, enforces refractory time.
module lif_neuron_fp32
  import snn_fp_pkg::*;
#(
  parameter logic [31:0] V_TH          = FP_POS_ONE,
  parameter logic [31:0] V_RESET       = FP_POS_ZERO,
  parameter int unsigned REFRAC_CYCLES = 2,
  parameter int unsigned REFRAC_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sum_valid,
  output logic        sum_ready,
  input  logic [31:0] sum_data,
  output logic [31:0] v_mem,
  output logic        refrac,
  output logic        spike_valid,
  input  logic        spike_ready,
  output logic        nan_err
);

  lif_state_t          state;
  logic [REFRAC_W-1:0] cnt;
  logic                at_th;
  logic                xfer;
  logic                in_nan;
  logic                in_ninf;

  fp32_ge_cmp u_th_cmp (
    .a  (sum_data),
    .b  (V_TH),
    .ge (at_th)
  );

  // Ready depends only on state; held low while reset is applied.
  always_comb begin
    sum_ready = rst_n && (state != FIRE);
    xfer      = sum_valid && sum_ready;
    in_nan    = is_nan(sum_data);
    in_ninf   = is_inf(sum_data) && sum_data[31];
  end

  // State register with membrane potential, spike handshake, refractory counter and sticky NaN flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= INTEG;
      v_mem       <= V_RESET;
      spike_valid <= 1'b0;
      refrac      <= 1'b0;
      nan_err     <= 1'b0;
      cnt         <= '0;
    end else begin
      if (xfer && in_nan) begin
        nan_err <= 1'b1;
      end
      case (state)
        INTEG: begin
          if (xfer) begin
            if (in_nan || in_ninf) begin
              v_mem <= V_RESET;
            end else if (at_th) begin
              v_mem       <= V_RESET;
              spike_valid <= 1'b1;
              state       <= FIRE;
            end else begin
              v_mem <= sum_data;
            end
          end
        end
        FIRE: begin
          if (spike_ready) begin
            spike_valid <= 1'b0;
            if (REFRAC_CYCLES > 0) begin
              cnt    <= REFRAC_W'(REFRAC_CYCLES);
              refrac <= 1'b1;
              state  <= REFRAC;
            end else begin
              state <= INTEG;
            end
          end
        end
        REFRAC: begin
          v_mem <= V_RESET;
          if (cnt == REFRAC_W'(1)) begin
            cnt    <= '0;
            refrac <= 1'b0;
            state  <= INTEG;
          end else if (cnt != '0) begin
            cnt <= cnt - REFRAC_W'(1);
          end
        end
        default: begin
          state <= INTEG;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_fp32.sv
// Directed self-checking bench for lif_neuron_fp32.
module tb_lif_neuron_fp32;

  logic        clk;
  logic        rst_n;
  logic        sum_valid;
  logic        sum_ready;
  logic [31:0] sum_data;
  logic [31:0] v_mem;
  logic        refrac;
  logic        spike_valid;
  logic        spike_ready;
  logic        nan_err;

  int checks = 0;
  int errors = 0;

  lif_neuron_fp32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sum_valid   (sum_valid),
    .sum_ready   (sum_ready),
    .sum_data    (sum_data),
    .v_mem       (v_mem),
    .refrac      (refrac),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .nan_err     (nan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] vm, input logic sv,
                         input logic sr, input logic rf, input logic ne);
    chk({tag, ".v_mem"},       v_mem,                vm);
    chk({tag, ".spike_valid"}, 32'(spike_valid),     32'(sv));
    chk({tag, ".sum_ready"},   32'(sum_ready),       32'(sr));
    chk({tag, ".refrac"},      32'(refrac),          32'(rf));
    chk({tag, ".nan_err"},     32'(nan_err),         32'(ne));
  endtask

  task automatic send(input logic [31:0] d);
    sum_data  = d;
    sum_valid = 1'b1;
    tick();
  endtask

  initial begin
    // 1. Reset with a valid sum present
    rst_n       = 1'b0;
    sum_valid   = 1'b1;
    sum_data    = 32'h4000_0000;
    spike_ready = 1'b0;
    #1;
    chk("rst_ready_early", 32'(sum_ready), 32'd0);
    tick();
    tick();
    chk_out("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n     = 1'b1;
    sum_valid = 1'b0;
    tick();
    chk_out("post_rst", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 2. Sub-threshold integration
    send(32'h3F00_0000);
    chk_out("half", 32'h3F00_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'h3F40_0000);
    chk_out("three_q", 32'h3F40_0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // 3. Exactly threshold fires; spike held while FIFO is full
    send(32'h3F80_0000);
    chk_out("fire_eq", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    sum_data = 32'h4000_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("fire_hold", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    spike_ready = 1'b1;
    tick();
    chk_out("refrac1", 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    spike_ready = 1'b0;
    sum_data    = 32'h3F00_0000;
    tick();
    chk_out("refrac2", 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("refrac_end", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("integ_first", 32'h3F00_0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // 4. NaN sticky, +Inf fires, -Inf resets
    send(32'h7FC0_0000);
    chk_out("nan", 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'h3F00_0000);
    chk_out("nan_sticky", 32'h3F00_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'h7F80_0000);
    chk_out("pinf", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    sum_valid   = 1'b0;
    spike_ready = 1'b1;
    tick();
    chk_out("pinf_ack", 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    spike_ready = 1'b0;
    tick();
    tick();
    chk_out("pinf_refrac_end", 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'h3F00_0000);
    chk_out("pre_ninf", 32'h3F00_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'hFF80_0000);
    chk_out("ninf", 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);

    // 5. Sign/zero edges; stray spike_ready in INTEG is ignored
    spike_ready = 1'b1;
    send(32'h8000_0000);
    chk_out("neg_zero", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    spike_ready = 1'b0;
    send(32'h0000_0001);
    chk_out("denorm", 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'hBF80_0000);
    chk_out("neg_one", 32'hBF80_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'h3F7F_FFFF);
    chk_out("below_th", 32'h3F7F_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'h3F80_0001);
    chk_out("above_th", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // 6. Reset during FIRE drops the pending spike
    rst_n = 1'b0;
    tick();
    chk_out("rst_fire", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n     = 1'b1;
    sum_valid = 1'b0;
    tick();
    chk_out("rst_fire_after", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
